// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1331 sprite path.
// Holds frame geometry defaults, sprite size, ROM address fields and fetch states.
package oled_pkg;

   localparam int H_RES_DEFAULT = 96;
   localparam int V_RES_DEFAULT = 64;

   localparam int SPRITE_W = 16;
   localparam int SPRITE_H = 16;

   localparam int FRAME_W = 3;
   localparam int ROW_W   = 4;
   localparam int BYTE_W  = 1;
   localparam int ADDR_W  = FRAME_W + ROW_W + BYTE_W;

   typedef logic [15:0] rgb565_t;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_LO,
      FS_HI,
      FS_DONE
   } fetch_state_t;

endpackage

// File: rtl/sprite_row_fetch.sv
// Prefetches the next scanline's 16-bit sprite row from the 1bpp ROM.
// Ports: clk/rst_n, i_x/i_y/i_next_pixel scan position, i_sx/i_sy/i_frame/
// i_mirror/i_en committed sprite params, o_rom_addr/i_rom_bits ROM port,
// i_swap line-end strobe, o_pend_* prefetched row bundle.
module sprite_row_fetch
   import oled_pkg::*;
#(
   parameter int V_RES      = V_RES_DEFAULT,
   parameter int PREFETCH_X = 80
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        i_x,
   input  logic [5:0]        i_y,
   input  logic              i_next_pixel,
   input  logic [6:0]        i_sx,
   input  logic [5:0]        i_sy,
   input  logic [2:0]        i_frame,
   input  logic              i_mirror,
   input  logic              i_en,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [7:0]        i_rom_bits,
   input  logic              i_swap,
   output logic [15:0]       o_pend_bits,
   output logic              o_pend_hit,
   output logic [6:0]        o_pend_x,
   output logic              o_pend_mirror
);

   fetch_state_t r_state;
   fetch_state_t w_next;

   logic [5:0]  r_ty;
   logic [15:0] r_bits;
   logic        r_hit;
   logic [6:0]  r_px;
   logic        r_mirror;

   logic       w_trig;
   logic       w_start;
   logic [6:0] w_row;
   logic       w_hit;
   logic [7:0] w_byte;

   assign w_trig  = i_next_pixel && (i_x == 7'(PREFETCH_X));
   assign w_start = (r_state == FS_IDLE) && w_trig;

   // 7-bit difference so rows above the sprite wrap to >= 16 and miss
   assign w_row  = {1'b0, r_ty} - {1'b0, i_sy};
   assign w_hit  = i_en && (w_row < 7'(SPRITE_H));
   assign w_byte = w_hit ? i_rom_bits : 8'h00;

   always_comb begin
      w_next     = r_state;
      o_rom_addr = '0;
      unique case (r_state)
         FS_IDLE: begin
            if (w_trig) w_next = FS_LO;
         end
         FS_LO: begin
            o_rom_addr = {i_frame, w_row[3:0], 1'b0};
            w_next     = FS_HI;
         end
         FS_HI: begin
            o_rom_addr = {i_frame, w_row[3:0], 1'b1};
            w_next     = FS_DONE;
         end
         FS_DONE: begin
            if (i_swap) w_next = FS_IDLE;
         end
         default: w_next = FS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= FS_IDLE;
         r_ty     <= '0;
         r_bits   <= '0;
         r_hit    <= 1'b0;
         r_px     <= '0;
         r_mirror <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_ty <= (i_y == 6'(V_RES - 1)) ? 6'd0 : i_y + 6'd1;
         end
         if (r_state == FS_LO) begin
            r_bits[7:0] <= w_byte;
            r_hit       <= w_hit;
            r_px        <= i_sx;
            r_mirror    <= i_mirror;
         end
         if (r_state == FS_HI) begin
            r_bits[15:8] <= w_byte;
         end
      end
   end

   // A swap while a fetch is in flight (or starting) hands stale data
   // to the display line; only a misplaced PREFETCH_X can cause it.
   always @(posedge clk) begin
      if (rst_n && i_swap) begin
         assert (r_state == FS_DONE ||
                 (r_state == FS_IDLE && !w_trig))
         else $error("sprite_row_fetch: swap before row fetch done");
      end
   end

   assign o_pend_bits   = r_bits;
   assign o_pend_hit    = r_hit;
   assign o_pend_x      = r_px;
   assign o_pend_mirror = r_mirror;

endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel RGB565 source for oled_video: one 16x16 1bpp sprite over bg.
// Ports: clk/rst_n, x/y/next_pixel scan, color out, rom_addr/rom_bits ROM,
// pos_valid/pos_ready + pos_x/pos_y/pos_frame/pos_mirror/pos_en update.
module sprite_compositor
   import oled_pkg::*;
#(
   parameter int      H_RES      = H_RES_DEFAULT,
   parameter int      V_RES      = V_RES_DEFAULT,
   parameter int      PREFETCH_X = 80,
   parameter rgb565_t FG_COLOR   = 16'hFFE0,
   parameter rgb565_t BG_COLOR   = 16'h0010
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        x,
   input  logic [5:0]        y,
   input  logic              next_pixel,
   output rgb565_t           color,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_bits,
   input  logic              pos_valid,
   output logic              pos_ready,
   input  logic [6:0]        pos_x,
   input  logic [5:0]        pos_y,
   input  logic [2:0]        pos_frame,
   input  logic              pos_mirror,
   input  logic              pos_en
);

   logic       r_free;
   logic [6:0] r_sh_x;
   logic [5:0] r_sh_y;
   logic [2:0] r_sh_frame;
   logic       r_sh_mirror;
   logic       r_sh_en;

   logic [6:0] r_fx;
   logic [5:0] r_fy;
   logic [2:0] r_ff;
   logic       r_fm;
   logic       r_fen;

   logic [15:0] r_cur_bits;
   logic        r_cur_hit;
   logic [6:0]  r_cur_x;
   logic        r_cur_mirror;
   rgb565_t     r_color;

   logic        w_commit;
   logic        w_xfer;
   logic        w_swap;
   logic [15:0] w_pend_bits;
   logic        w_pend_hit;
   logic [6:0]  w_pend_x;
   logic        w_pend_mirror;
   logic [6:0]  w_c;
   logic        w_in;
   logic [3:0]  w_idx;

   assign w_commit = next_pixel && (x == 7'(PREFETCH_X))
                     && (y == 6'(V_RES - 1));
   assign w_swap   = next_pixel && (x == 7'(H_RES - 1));

   // The commit cycle blocks new transfers, even into an empty slot
   assign pos_ready = r_free && !w_commit;
   assign w_xfer    = pos_valid && pos_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_free      <= 1'b1;
         r_sh_x      <= '0;
         r_sh_y      <= '0;
         r_sh_frame  <= '0;
         r_sh_mirror <= 1'b0;
         r_sh_en     <= 1'b0;
         r_fx        <= '0;
         r_fy        <= '0;
         r_ff        <= '0;
         r_fm        <= 1'b0;
         r_fen       <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_free      <= 1'b0;
            r_sh_x      <= pos_x;
            r_sh_y      <= pos_y;
            r_sh_frame  <= pos_frame;
            r_sh_mirror <= pos_mirror;
            r_sh_en     <= pos_en;
         end
         if (w_commit && !r_free) begin
            r_free <= 1'b1;
            r_fx   <= r_sh_x;
            r_fy   <= r_sh_y;
            r_ff   <= r_sh_frame;
            r_fm   <= r_sh_mirror;
            r_fen  <= r_sh_en;
         end
      end
   end

   sprite_row_fetch #(
      .V_RES      (V_RES),
      .PREFETCH_X (PREFETCH_X)
   ) u_fetch (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_x           (x),
      .i_y           (y),
      .i_next_pixel  (next_pixel),
      .i_sx          (r_fx),
      .i_sy          (r_fy),
      .i_frame       (r_ff),
      .i_mirror      (r_fm),
      .i_en          (r_fen),
      .o_rom_addr    (rom_addr),
      .i_rom_bits    (rom_bits),
      .i_swap        (w_swap),
      .o_pend_bits   (w_pend_bits),
      .o_pend_hit    (w_pend_hit),
      .o_pend_x      (w_pend_x),
      .o_pend_mirror (w_pend_mirror)
   );

   // Columns left of the sprite wrap to large c and fall outside
   assign w_c   = x - r_cur_x;
   assign w_in  = r_cur_hit && (w_c < 7'(SPRITE_W));
   assign w_idx = r_cur_mirror ? 4'd15 - w_c[3:0] : w_c[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_bits   <= '0;
         r_cur_hit    <= 1'b0;
         r_cur_x      <= '0;
         r_cur_mirror <= 1'b0;
         r_color      <= BG_COLOR;
      end else begin
         if (w_swap) begin
            r_cur_bits   <= w_pend_bits;
            r_cur_hit    <= w_pend_hit;
            r_cur_x      <= w_pend_x;
            r_cur_mirror <= w_pend_mirror;
         end
         r_color <= (w_in && r_cur_bits[w_idx]) ? FG_COLOR : BG_COLOR;
      end
   end

   assign color = r_color;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: scans whole frames like
// oled_video and checks color/pos_ready against a frame-level sprite model.
module tb_sprite_compositor;

   localparam int H  = 96;
   localparam int V  = 64;
   localparam int PX = 80;
   localparam logic [15:0] FG = 16'hFFE0;
   localparam logic [15:0] BG = 16'h0010;

   typedef struct packed {
      logic [6:0] x;
      logic [5:0] y;
      logic [2:0] f;
      logic       m;
      logic       en;
   } req_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  x;
   logic [5:0]  y;
   logic        next_pixel;
   logic [15:0] color;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_bits;
   logic        pos_valid;
   logic        pos_ready;
   logic [6:0]  pos_x;
   logic [5:0]  pos_y;
   logic [2:0]  pos_frame;
   logic        pos_mirror;
   logic        pos_en;

   logic [7:0]  rom_mem [256];
   logic [15:0] cap [64][96];

   int    checks = 0;
   int    failures = 0;
   req_t  m_sh, m_next, p_frame;
   bit    m_full;
   req_t  rq[$];
   bit    presenting;
   int    st_y, st_x, st_b;
   int    acc_q[$];
   int    px_bad, rdy_bad;
   string first_px, first_rdy;

   assign rom_bits = rom_mem[rom_addr];

   always #20 clk = ~clk;

   sprite_compositor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .x          (x),
      .y          (y),
      .next_pixel (next_pixel),
      .color      (color),
      .rom_addr   (rom_addr),
      .rom_bits   (rom_bits),
      .pos_valid  (pos_valid),
      .pos_ready  (pos_ready),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .pos_frame  (pos_frame),
      .pos_mirror (pos_mirror),
      .pos_en     (pos_en)
   );

   function automatic logic [15:0] exp_px(int px, int py, req_t p);
      int c, r, idx;
      logic [15:0] w;
      if (!p.en) return BG;
      if (py < int'(p.y) || py >= int'(p.y) + 16) return BG;
      if (px < int'(p.x) || px >= int'(p.x) + 16) return BG;
      c = px - int'(p.x);
      r = py - int'(p.y);
      w = {rom_mem[{p.f, 4'(r), 1'b1}], rom_mem[{p.f, 4'(r), 1'b0}]};
      idx = p.m ? 15 - c : c;
      return w[idx] ? FG : BG;
   endfunction

   function automatic req_t rnd_req(bit force_en, bit nz_frame);
      req_t r;
      r.x  = 7'($urandom_range(0, H - 1));
      r.y  = 6'($urandom_range(0, V - 1));
      r.f  = 3'($urandom_range(nz_frame ? 1 : 0, 7));
      r.m  = 1'($urandom_range(0, 1));
      r.en = force_en ? 1'b1 : 1'($urandom_range(0, 1));
      return r;
   endfunction

   task automatic drive_req(req_t r);
      pos_x      = r.x;
      pos_y      = r.y;
      pos_frame  = r.f;
      pos_mirror = r.m;
      pos_en     = r.en;
   endtask

   task automatic maybe_start(int yy, int xx, int b);
      if (!presenting && rq.size() > 0 && yy == st_y && xx == st_x
          && b == st_b) begin
         presenting = 1;
         drive_req(rq[0]);
         pos_valid = 1'b1;
      end
   endtask

   task automatic cyc(int b, int xx, int yy);
      bit cm, er, xf;
      logic [15:0] e;
      @(negedge clk);
      cm = next_pixel && xx == PX && yy == V - 1;
      er = !m_full && !cm;
      if (pos_ready !== er) begin
         if (rdy_bad == 0)
            first_rdy = $sformatf("(%0d,%0d,%0d) got %b want %b",
                                  xx, yy, b, pos_ready, er);
         rdy_bad++;
      end
      if (b == 1) begin
         cap[yy][xx] = color;
         e = exp_px(xx, yy, p_frame);
         if (color !== e) begin
            if (px_bad == 0)
               first_px = $sformatf("(%0d,%0d) got %h want %h",
                                    xx, yy, color, e);
            px_bad++;
         end
      end
      xf = pos_valid && er;
      @(posedge clk);
      #1;
      if (cm && m_full) begin
         m_next = m_sh;
         m_full = 0;
      end
      if (xf) begin
         m_sh   = rq.pop_front();
         m_full = 1;
         acc_q.push_back(yy * 256 + xx * 2 + b);
         if (rq.size() > 0) drive_req(rq[0]);
         else begin
            pos_valid  = 1'b0;
            presenting = 0;
         end
      end
   endtask

   task automatic scan(int ya, int xa, int yb, int xb);
      int xx, yy;
      xx = xa;
      yy = ya;
      px_bad = 0;
      rdy_bad = 0;
      while (1) begin
         if (xx == 0 && yy == 0) p_frame = m_next;
         x = 7'(xx);
         y = 6'(yy);
         next_pixel = 1'b0;
         maybe_start(yy, xx, 0);
         cyc(0, xx, yy);
         next_pixel = 1'b1;
         maybe_start(yy, xx, 1);
         cyc(1, xx, yy);
         if (yy == yb && xx == xb) break;
         xx++;
         if (xx == H) begin
            xx = 0;
            yy = (yy == V - 1) ? 0 : yy + 1;
         end
      end
      next_pixel = 1'b0;
   endtask

   task automatic check_scan(string tag);
      checks++;
      if (px_bad !== 0) begin
         failures++;
         $display("FAIL %s_pixels: %0d bad, first %s", tag, px_bad, first_px);
      end
      checks++;
      if (rdy_bad !== 0) begin
         failures++;
         $display("FAIL %s_ready: %0d bad, first %s", tag, rdy_bad,
                  first_rdy);
      end
   endtask

   function automatic int count_fg(int y0, int y1, int x0, int x1,
                                   bit outside);
      int n = 0;
      for (int yy = 0; yy < V; yy++)
         for (int xx = 0; xx < H; xx++) begin
            bit inb = yy >= y0 && yy <= y1 && xx >= x0 && xx <= x1;
            if ((inb != outside) && cap[yy][xx] === FG) n++;
         end
      return n;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      x = '0;
      y = '0;
      next_pixel = 1'b0;
      pos_valid = 1'b0;
      drive_req('0);
      m_full = 0;
      m_next = '0;
      m_sh = '0;
      p_frame = '0;
      presenting = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (color !== BG) begin
         failures++;
         $display("FAIL reset_color: got %h want %h", color, BG);
      end
      checks++;
      if (rom_addr !== 8'h00) begin
         failures++;
         $display("FAIL reset_rom_addr: got %h want 00", rom_addr);
      end
      checks++;
      if (pos_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_pos_ready: got %b want 1", pos_ready);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_idle_frame();
      scan(0, 0, V - 1, H - 1);
      check_scan("idle");
      checks++;
      if (count_fg(0, V - 1, 0, H - 1, 0) !== 0) begin
         failures++;
         $display("FAIL idle_no_fg: got %0d fg pixels want 0",
                  count_fg(0, V - 1, 0, H - 1, 0));
      end
   endtask

   task automatic test_update_midframe();
      req_t s = '{x: 7'd10, y: 6'd5, f: 3'd0, m: 1'b0, en: 1'b1};
      acc_q.delete();
      rq.push_back(s);
      st_y = 5; st_x = 0; st_b = 0;
      scan(0, 0, V - 1, H - 1);
      check_scan("update");
      checks++;
      if (count_fg(0, V - 1, 0, H - 1, 0) !== 0) begin
         failures++;
         $display("FAIL update_same_frame: got %0d fg want 0",
                  count_fg(0, V - 1, 0, H - 1, 0));
      end
      checks++;
      if (acc_q.size() != 1 || acc_q[0] !== 5 * 256) begin
         failures++;
         $display("FAIL update_accept: got %0d accepts want one at row 5",
                  acc_q.size());
      end
   endtask

   task automatic test_sprite();
      req_t s = '{x: 7'd10, y: 6'd5, f: 3'd0, m: 1'b1, en: 1'b1};
      rq.push_back(s);
      st_y = 20; st_x = 0; st_b = 0;
      scan(0, 0, V - 1, H - 1);
      check_scan("sprite");
      checks++;
      if (cap[5][17] !== FG) begin
         failures++;
         $display("FAIL sprite_17_5: got %h want %h", cap[5][17], FG);
      end
      checks++;
      if (cap[5][10] !== BG) begin
         failures++;
         $display("FAIL sprite_10_5: got %h want %h", cap[5][10], BG);
      end
   endtask

   task automatic test_mirror_back_to_back();
      req_t a, b;
      a = rnd_req(1, 0);
      a.x = 7'd90;
      a.y = 6'd60;
      b = rnd_req(1, 1);
      acc_q.delete();
      rq.push_back(a);
      rq.push_back(b);
      st_y = 30; st_x = 0; st_b = 0;
      scan(0, 0, V - 1, H - 1);
      check_scan("mirror");
      checks++;
      if (cap[5][18] !== FG) begin
         failures++;
         $display("FAIL mirror_18_5: got %h want %h", cap[5][18], FG);
      end
      checks++;
      if (cap[5][17] !== FG) begin
         failures++;
         $display("FAIL mirror_17_5: got %h want %h", cap[5][17], FG);
      end
      checks++;
      if (acc_q.size() != 2) begin
         failures++;
         $display("FAIL b2b_count: got %0d accepts want 2", acc_q.size());
      end else begin
         checks++;
         if (acc_q[0] !== 30 * 256) begin
            failures++;
            $display("FAIL b2b_first: got %0d want %0d", acc_q[0], 30 * 256);
         end
         checks++;
         if (acc_q[1] !== 63 * 256 + 81 * 2) begin
            failures++;
            $display("FAIL b2b_second: got %0d want %0d", acc_q[1],
                     63 * 256 + 81 * 2);
         end
      end
   endtask

   task automatic test_clip();
      scan(0, 0, V - 1, H - 1);
      check_scan("clip");
      checks++;
      if (count_fg(60, 63, 90, 95, 1) !== 0) begin
         failures++;
         $display("FAIL clip_outside: got %0d fg outside box want 0",
                  count_fg(60, 63, 90, 95, 1));
      end
   endtask

   task automatic test_commit_collision();
      acc_q.delete();
      rq.push_back(rnd_req(0, 0));
      st_y = 63; st_x = PX; st_b = 1;
      scan(0, 0, V - 1, H - 1);
      check_scan("collide");
      checks++;
      if (acc_q.size() != 1 || acc_q[0] !== 63 * 256 + 81 * 2) begin
         failures++;
         $display("FAIL collide_accept: got %0d accepts want one after commit",
                  acc_q.size());
      end
   endtask

   task automatic test_reset_mid_fetch();
      int row;
      logic [7:0] ea;
      scan(0, 0, 1, PX);
      check_scan("prefetch");
      row = (2 - int'(m_next.y)) & 15;
      ea = {m_next.f, 4'(row), 1'b0};
      checks++;
      if (rom_addr !== ea) begin
         failures++;
         $display("FAIL lo_rom_addr: got %h want %h", rom_addr, ea);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (rom_addr !== 8'h00 || color !== BG) begin
         failures++;
         $display("FAIL async_reset: got addr %h color %h want 00 %h",
                  rom_addr, color, BG);
      end
      checks++;
      if (pos_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset_ready: got %b want 1", pos_ready);
      end
      rq.delete();
      pos_valid = 1'b0;
      presenting = 0;
      m_full = 0;
      m_next = '0;
      m_sh = '0;
      p_frame = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checks++;
      if (rom_addr !== 8'h00) begin
         failures++;
         $display("FAIL post_reset_addr: got %h want 00", rom_addr);
      end
      scan(1, PX + 1, 8, H - 1);
      check_scan("post_reset");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
      rom_mem[0] = 8'h80;
      rom_mem[1] = 8'h07;
      test_reset();
      test_idle_frame();
      test_update_midframe();
      test_sprite();
      test_mirror_back_to_back();
      test_clip();
      test_commit_collision();
      test_reset_mid_fetch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Per-pixel colour source for the SSD1331 OLED path. It sits between the 1bpp sprite bitmap ROM and `oled_video`, consuming that driver's `x`, `y` and `next_pixel` and returning the RGB565 `color` for the pixel being shifted out. It prefetches one 16-bit sprite row per scanline into a double buffer. A sprite position/frame update handshake is applied atomically at frame boundaries, so sprites never tear.

## Interface

Parameters:
- `H_RES`, 96: OLED columns.
- `V_RES`, 64: OLED rows.
- `PREFETCH_X`, 80: column at which the next line's row fetch starts; legal range 0..H_RES-2.
- `FG_COLOR`, 16'hFFE0: RGB565 colour for set sprite pixels.
- `BG_COLOR`, 16'h0010: RGB565 colour for background.

Ports:
- `clk` in 1: system clock, 25 MHz. One clock; everything runs in this domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `x` in 7: current pixel column from `oled_video`.
- `y` in 6: current pixel row from `oled_video`.
- `next_pixel` in 1: one-cycle pulse; `x`/`y` advance after it.
- `color` out 16: RGB565 colour for the current (`x`,`y`).
- `rom_addr` out 8: sprite ROM byte address, {frame[2:0], row[3:0], byte}.
- `rom_bits` in 8: ROM data. The ROM is combinational, so data is valid in the same cycle as the address.
- `pos_valid` in 1: update request.
- `pos_ready` out 1: update slot free.
- `pos_x` in 7: sprite left column.
- `pos_y` in 6: sprite top row.
- `pos_frame` in 3: sprite frame index.
- `pos_mirror` in 1: horizontal mirror.
- `pos_en` in 1: sprite visible.

## Operation

- Update handshake:
  - A transfer occurs when `pos_valid && pos_ready`; the fields are captured into a shadow slot and `pos_ready` drops.
  - The shadow slot is committed to the fetch parameters on `next_pixel` with `x==PREFETCH_X && y==V_RES-1`. The commit happens before that fetch starts, so line 0 of the next frame uses the new values.
  - `pos_ready` rises the cycle after the commit.
- Row fetch FSM:
  - States: IDLE, LO, HI, DONE.
  - IDLE→LO on `next_pixel && x==PREFETCH_X`. The target line is ty = (y==V_RES-1) ? 0 : y+1.
  - LO: drive addr {frame, ty-sy, 0}; latch `rom_bits` into pend[7:0]; go to HI.
  - HI: drive addr {frame, ty-sy, 1}; latch `rom_bits` into pend[15:8]; go to DONE.
  - DONE: hold pend until the swap, then return to IDLE.
  - pend_hit = en && (ty-sy, 7-bit unsigned) < 16. When pend_hit is 0 the ROM reads are still issued, but pend is forced to 0.
  - pend_x and pend_mirror are latched together with the row.
- Swap: on `next_pixel && x==H_RES-1`, copy pend, pend_hit, pend_x and pend_mirror into the cur registers.
- Pixel:
  - c = x - cur_x, 7-bit.
  - in = cur_hit && c < 16.
  - bit = cur_bits[cur_mirror ? 15-c[3:0] : c[3:0]].
  - `color` <= (in && bit) ? FG_COLOR : BG_COLOR.
- Bit 0 of a row word is the leftmost pixel.
- A sprite that crosses the right edge is clipped. There is no wrap onto the next line; pixels with x ≥ H_RES are never requested.
- Reset:
  - `color`=BG_COLOR, `rom_addr`=0, `pos_ready`=1.
  - All cur/pend/fetch registers are cleared, with en=0; the FSM goes to IDLE.
  - An asserted reset mid-fetch or mid-frame aborts the fetch. After reset release, output is background until the first swap following a committed update with en=1.

## Timing

- `color` is registered and reflects (`x`,`y`) one clk after they change.
- `oled_video` holds each pixel for at least 16 clk, so a 1-cycle latency is invisible.
- Fetch is 2 clk after the trigger and completes ≥ 13 pixels before the swap.
- Boundary cases:
  - If a `next_pixel` trigger arrives while the FSM is not IDLE (protocol violation), it is ignored.
  - If commit and a new handshake coincide, the commit wins and `pos_ready` stays low that cycle.
  - A swap before DONE (only possible if PREFETCH_X ≥ H_RES-1) copies stale pend; this is a configuration error and must be flagged by a simulation assertion.
  - `pos_y` near V_RES-1 clips at the bottom: rows with ty-sy ≥ 16 are not hit.

## Structure

- `oled_pkg` holds:
  - H_RES_DEFAULT and V_RES_DEFAULT.
  - The `rgb565_t` typedef.
  - SPRITE_W=16, SPRITE_H=16.
  - The fetch-state enum.
  - ROM address field widths.
- One sub-module, `sprite_row_fetch`, contains the FSM, the ROM address generation and the pend registers. The top level holds the handshake, the shadow slot, the cur registers and the colour mux.

## Test plan

- Reset, then a full frame with no update → every `color` sample equals 16'h0010 and `pos_ready`=1.
- Update (x=10, y=5, frame=0, en=1) mid-frame → no sprite pixels appear in the current frame. Next frame, pixel (17,5) = FG, because row 0 is 16'b11110000000 (bits 7-10 set) and c=7. Pixel (10,5) = BG.
- Same sprite with mirror=1 → pixel (18,5) = FG (15-8=7), and pixel (17,5) = FG (15-7=8 → bit 8 set).
- `pos_x`=90 → columns 90-95 are drawn from bits 0-5 and nothing appears on the next line's left edge. `pos_y`=60 → only rows 60-63 are drawn.
- Two back-to-back `pos_valid` → the first is accepted and `pos_ready` stays low until commit. The second is accepted the cycle after commit and appears one frame later.
- `rst_n` asserted during LO → `rom_addr`=0, `color`=BG immediately (asynchronous), FSM in IDLE after release.
